// File: rtl/lab3_step_sequencer.sv
// Run-control sequencer for the Lab 3 CPU: turns board switches and the centre button
// into a single-cycle cpu_en pulse stream and a stretched cpu_rst.
module lab3_step_sequencer #(
    parameter int TICK_DIV  = 1000000,
    parameter int DB_CYCLES = 500000,
    parameter int RST_HOLD  = 4
) (
    input  logic        fpga_clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        clr_req,
    input  logic        btnC,
    input  logic        instr_done,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic        busy,
    output logic [15:0] step_count,
    output logic [1:0]  fsm_state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_CYCLE = 2'b01;
    localparam logic [1:0] MODE_INSTR = 2'b10;

    typedef enum logic [1:0] {ST_RST_HOLD, ST_IDLE, ST_RUN, ST_INSTR_BUSY} state_t;

    state_t          state, state_d, follow_state;
    logic [1:0]      mode_s1, mode_s2, mode_q;
    logic            btn_s1, btn_s2, clr_s1, clr_s2;
    logic [DW-1:0]   db_cnt;
    logic            btn_db, btn_press;
    logic [TW-1:0]   tick_cnt;
    logic            tick, mode_chg;
    logic [HW-1:0]   hold_cnt;
    logic            rst_d, en_d;

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
            mode_q  <= 2'b00;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            clr_s1  <= 1'b0;
            clr_s2  <= 1'b0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            mode_q  <= mode_s2;
            btn_s1  <= btnC;
            btn_s2  <= btn_s1;
            clr_s1  <= clr_req;
            clr_s2  <= clr_s1;
        end
    end

    assign mode_chg = (mode_s2 != mode_q);

    // btn_press fires only on the 0->1 toggle of btn_db, so a held button yields one press.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_db    <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_press <= 1'b0;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db    <= ~btn_db;
                btn_press <= ~btn_db;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (reset || cpu_rst || mode_chg) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Next cpu_rst is known combinationally so cpu_en can be suppressed on the same edge.
    assign rst_d = reset | clr_s2 | (hold_cnt != '0);

    always_ff @(posedge fpga_clk) begin
        if (reset || clr_s2) begin
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
        cpu_rst <= rst_d;
    end

    assign follow_state = (mode_s2 == MODE_RUN) ? ST_RUN : ST_IDLE;

    always_comb begin
        state_d = state;
        en_d    = 1'b0;
        if (rst_d) begin
            state_d = ST_RST_HOLD;
        end else begin
            case (state)
                ST_RST_HOLD: state_d = follow_state;
                ST_IDLE, ST_RUN: begin
                    state_d = follow_state;
                    if (state == ST_RUN && mode_s2 == MODE_RUN) begin
                        en_d = tick;
                    end
                    if (state == ST_IDLE && btn_press) begin
                        if (mode_s2 == MODE_CYCLE) begin
                            en_d = 1'b1;
                        end else if (mode_s2 == MODE_INSTR) begin
                            state_d = ST_INSTR_BUSY;
                        end
                    end
                end
                ST_INSTR_BUSY: begin
                    if (mode_s2 != MODE_INSTR) begin
                        state_d = follow_state;
                    end else begin
                        en_d = tick;
                        if (cpu_en && instr_done) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_RST_HOLD;
            endcase
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state  <= ST_RST_HOLD;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            cpu_en <= en_d;
            busy   <= (state_d == ST_INSTR_BUSY);
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (reset || cpu_rst) begin
            step_count <= 16'h0000;
        end else begin
            step_count <= step_count + 16'(cpu_en);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_lab3_step_sequencer.sv
// Directed bench for lab3_step_sequencer with small TICK/DB/HOLD values so every
// pulse position can be worked out by hand.
module tb_lab3_step_sequencer;

    localparam int TICK_DIV  = 5;
    localparam int DB_CYCLES = 4;
    localparam int RST_HOLD  = 3;

    localparam logic [1:0] S_RST_HOLD = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_BUSY     = 2'd3;

    logic        fpga_clk = 1'b0;
    logic        reset, clr_req, btnC, instr_done;
    logic [1:0]  mode;
    logic        cpu_en, cpu_rst, busy;
    logic [15:0] step_count;
    logic [1:0]  fsm_state;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int en_total      = 0;
    int pulse_in_step = 0;
    int done_on       = 0;
    int inv_viol      = 0;
    int base          = 0;
    int first_en      = 0;
    logic prev_en     = 1'b0;

    lab3_step_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .fpga_clk   (fpga_clk),
        .reset      (reset),
        .mode       (mode),
        .clr_req    (clr_req),
        .btnC       (btnC),
        .instr_done (instr_done),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .step_count (step_count),
        .fsm_state  (fsm_state)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling 1ns after each edge; also acts as the CPU model.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            #1;
            if (cpu_en) begin
                en_total++;
                pulse_in_step++;
            end
            if (cpu_en && (cpu_rst || prev_en)) inv_viol++;
            prev_en    = cpu_en;
            instr_done = cpu_en && (done_on != 0) && (pulse_in_step == done_on);
        end
    endtask

    task automatic press();
        btnC = 1'b1;
        cyc(6);
        btnC = 1'b0;
        cyc(6);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; clr_req = 1'b0; btnC = 1'b0; instr_done = 1'b0;

        cyc(3);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_step_count", step_count, 0);
        check("rst_fsm", fsm_state, S_RST_HOLD);

        // Free run after reset release
        reset = 1'b0;
        base  = en_total;
        cyc(3);
        check("t1_rst_hold_last", cpu_rst, 1);
        cyc(1);
        check("t1_rst_drop", cpu_rst, 0);
        check("t1_fsm_run", fsm_state, S_RUN);
        for (int i = 5; i <= 25; i++) begin
            cyc(1);
            if (cpu_en && first_en == 0) first_en = i;
        end
        check("t1_first_en_cycle", first_en, 9);
        check("t1_en_pulses", en_total - base, 4);
        check("t1_step_count", step_count, 4);

        // Cycle step with a bouncy button
        mode = 2'b01;
        cyc(5);
        base = en_total;
        btnC = 1'b1; cyc(3);
        btnC = 1'b0; cyc(1);
        btnC = 1'b1; cyc(2);
        btnC = 1'b0; cyc(4);
        check("t2_bounce_no_pulse", en_total - base, 0);
        btnC = 1'b1; cyc(10);
        check("t2_one_pulse", en_total - base, 1);
        btnC = 1'b0; cyc(10);
        check("t2_no_release_pulse", en_total - base, 1);
        check("t2_step_count", step_count, 5);
        check("t2_busy", busy, 0);

        // Instruction step, retire on 3rd pulse, second press while busy
        mode = 2'b10;
        cyc(4);
        done_on = 3; pulse_in_step = 0; base = en_total;
        btnC = 1'b1; cyc(6);
        btnC = 1'b0; cyc(3);
        check("t3_busy_high", busy, 1);
        check("t3_fsm_busy", fsm_state, S_BUSY);
        cyc(1);
        btnC = 1'b1; cyc(6);
        btnC = 1'b0; cyc(24);
        check("t3_three_pulses", en_total - base, 3);
        check("t3_busy_low", busy, 0);
        cyc(10);
        check("t3_press_not_queued", en_total - base, 3);
        done_on = 0;

        // Abort an instruction step by switching to HALT
        btnC = 1'b1; cyc(6);
        btnC = 1'b0; cyc(2);
        check("t4_busy_before_abort", busy, 1);
        mode = 2'b11;
        cyc(3);
        check("t4_busy_aborted", busy, 0);
        check("t4_fsm_idle", fsm_state, S_IDLE);
        base = en_total;
        cyc(15);
        check("t4_no_pulse_halt", en_total - base, 0);

        // Clear request in the middle of a free run
        mode = 2'b00;
        cyc(10);
        clr_req = 1'b1; cyc(2);
        clr_req = 1'b0; cyc(1);
        check("t5_rst_asserted", cpu_rst, 1);
        base = en_total;
        cyc(1);
        check("t5_step_cleared", step_count, 0);
        cyc(3);
        check("t5_hold_last", cpu_rst, 1);
        cyc(1);
        check("t5_rst_drop", cpu_rst, 0);
        check("t5_step_zero", step_count, 0);
        cyc(4);
        check("t5_no_pulse_in_rst", en_total - base, 0);
        cyc(1);
        check("t5_fresh_phase_pulse", cpu_en, 1);
        cyc(1);
        check("t5_step_one", step_count, 1);

        // 16-bit wrap, then synchronous reset mid-step
        mode = 2'b11;
        cyc(6);
        force dut.step_count = 16'hFFFE;
        cyc(1);
        release dut.step_count;
        check("t6_preload", step_count, 16'hFFFE);
        mode = 2'b01;
        cyc(4);
        press();
        check("t6_ffff", step_count, 16'hFFFF);
        press();
        check("t6_wrap", step_count, 16'h0000);
        press();
        check("t6_after_wrap", step_count, 16'h0001);
        mode = 2'b10;
        cyc(4);
        btnC = 1'b1; cyc(6);
        btnC = 1'b0; cyc(2);
        check("t6_busy_before_reset", busy, 1);
        reset = 1'b1;
        cyc(1);
        check("t6_rst_cpu_en", cpu_en, 0);
        check("t6_rst_cpu_rst", cpu_rst, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_step_count", step_count, 0);
        check("t6_rst_fsm", fsm_state, S_RST_HOLD);
        reset = 1'b0;
        cyc(2);

        check("invariants", inv_viol, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
